// File: rtl/alu_step_sequencer_if.sv
// rtl/alu_step_sequencer_if.sv - datapath bundle between step sequencer and datapath
// Purpose: groups the instruction/memory inputs and every datapath strobe.
// Signals:
//   ir, mem_ready           datapath -> sequencer (instruction register, read data valid)
//   PCout..LOin             sequencer -> datapath single-bit strobes
//   Rin, Rout               sequencer -> datapath one-hot register load / drive
//   alu_op, alu_go          sequencer -> datapath ALU operation and its valid
// Modports: master = sequencer side, slave = datapath side.
interface alu_step_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int NREG   = 16
);
   logic [DATA_W-1:0] ir;
   logic              mem_ready;
   logic              PCout, IncPC, MARin, Zin, Zlowout, ZHighout, PCin;
   logic              Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
   logic [NREG-1:0]   Rin;
   logic [NREG-1:0]   Rout;
   logic [4:0]        alu_op;
   logic              alu_go;

   modport master (
      input  ir, mem_ready,
      output PCout, IncPC, MARin, Zin, Zlowout, ZHighout, PCin,
             Read, MDRin, MDRout, IRin, Yin, HIin, LOin,
             Rin, Rout, alu_op, alu_go
   );

   modport slave (
      output ir, mem_ready,
      input  PCout, IncPC, MARin, Zin, Zlowout, ZHighout, PCin,
             Read, MDRin, MDRout, IRin, Yin, HIin, LOin,
             Rin, Rout, alu_op, alu_go
   );
endinterface

// File: rtl/alu_step_sequencer.sv
// rtl/alu_step_sequencer.sv - fetch/decode/execute step sequencer for a register ALU datapath
// Purpose: walks IDLE, T0, T1, T1W, T2..T6 and raises datapath strobes per step.
// Ports:
//   clock     rising-edge clock
//   clear     synchronous active-low reset
//   run       start from IDLE / continue after the last step
//   busy      high in every state except IDLE
//   done      one-cycle pulse on the last step of an instruction
//   illegal   one-cycle pulse in T3 for an undefined opcode
//   fault     one-cycle pulse when the memory wait runs out
//   dp        datapath bundle (master side)
module alu_step_sequencer #(
   parameter int DATA_W   = 32,
   parameter int NREG     = 16,
   parameter int REG_W    = $clog2(NREG),
   parameter int WAIT_MAX = 15
) (
   input  logic clock,
   input  logic clear,
   input  logic run,
   output logic busy,
   output logic done,
   output logic illegal,
   output logic fault,
   alu_step_sequencer_if.master dp
);
   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;

   logic [4:0]       opcode;
   logic [REG_W-1:0] ra, rb, rc;
   logic             legal, unary, wide, wait_last;
   logic             unused_ir;

   // ir is loaded by IRin at the end of T2, so decode stays combinational:
   // T3 onward sees the freshly loaded instruction.
   assign opcode = dp.ir[DATA_W-1 -: 5];
   assign ra     = dp.ir[DATA_W-6 -: REG_W];
   assign rb     = dp.ir[DATA_W-6-REG_W -: REG_W];
   assign rc     = dp.ir[DATA_W-6-2*REG_W -: REG_W];
   assign unused_ir = ^dp.ir;

   assign legal = (opcode <= 5'b01011);
   assign unary = (opcode == 5'b01010) || (opcode == 5'b01011);
   assign wide  = (opcode == 5'b01000) || (opcode == 5'b01001);

   // Counter holds (number of T1W cycles already completed); the WAIT_MAX-th
   // wait cycle is the one where it equals WAIT_MAX-1.
   assign wait_last = (wait_cnt == CNT_W'(WAIT_MAX - 1));

   // Register fields that do not name an existing register select nothing.
   function automatic logic [NREG-1:0] onehot(input logic [REG_W-1:0] idx);
      onehot = '0;
      if (int'(idx) < NREG) onehot[idx] = 1'b1;
   endfunction

   always_ff @(posedge clock) begin
      if (!clear) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: if (run) state <= S_T0;
            S_T0:   state <= S_T1;
            S_T1: begin
               if (dp.mem_ready) begin
                  state <= S_T2;
               end else begin
                  state    <= S_T1W;
                  wait_cnt <= '0;
               end
            end
            S_T1W: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (dp.mem_ready)  state <= S_T2;
               else if (wait_last) state <= S_IDLE;
            end
            S_T2: state <= S_T3;
            S_T3: begin
               if (!legal)     state <= run ? S_T0 : S_IDLE;
               else if (unary) state <= S_T5;
               else            state <= S_T4;
            end
            S_T4: state <= S_T5;
            S_T5: begin
               if (wide) state <= S_T6;
               else      state <= run ? S_T0 : S_IDLE;
            end
            S_T6:    state <= run ? S_T0 : S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      dp.PCout = 1'b0; dp.IncPC = 1'b0; dp.MARin = 1'b0; dp.Zin = 1'b0;
      dp.Zlowout = 1'b0; dp.ZHighout = 1'b0; dp.PCin = 1'b0; dp.Read = 1'b0;
      dp.MDRin = 1'b0; dp.MDRout = 1'b0; dp.IRin = 1'b0; dp.Yin = 1'b0;
      dp.HIin = 1'b0; dp.LOin = 1'b0;
      dp.Rin = '0; dp.Rout = '0; dp.alu_op = 5'b0; dp.alu_go = 1'b0;
      busy = (state != S_IDLE);
      done = 1'b0; illegal = 1'b0; fault = 1'b0;
      case (state)
         S_T0: begin
            dp.PCout = 1'b1; dp.IncPC = 1'b1; dp.Zin = 1'b1; dp.MARin = 1'b1;
         end
         S_T1: begin
            dp.Zlowout = 1'b1; dp.PCin = 1'b1; dp.Read = 1'b1; dp.MDRin = 1'b1;
         end
         S_T1W: begin
            dp.Read = 1'b1; dp.MDRin = 1'b1;
            fault   = !dp.mem_ready && wait_last;
         end
         S_T2: begin
            dp.MDRout = 1'b1; dp.IRin = 1'b1;
         end
         S_T3: begin
            if (!legal) begin
               illegal = 1'b1;
            end else if (unary) begin
               dp.Rout = onehot(rb); dp.alu_go = 1'b1; dp.alu_op = opcode; dp.Zin = 1'b1;
            end else begin
               dp.Rout = onehot(rb); dp.Yin = 1'b1;
            end
         end
         S_T4: begin
            dp.Rout = onehot(rc); dp.alu_go = 1'b1; dp.alu_op = opcode; dp.Zin = 1'b1;
         end
         S_T5: begin
            dp.Zlowout = 1'b1;
            if (wide) begin
               dp.LOin = 1'b1;
            end else begin
               dp.Rin = onehot(ra);
               done   = 1'b1;
            end
         end
         S_T6: begin
            dp.ZHighout = 1'b1; dp.HIin = 1'b1; done = 1'b1;
         end
         default: ;
      endcase
   end
endmodule
